// File: rtl/alu_pipe.sv
// Handshaked integer ALU: 1-cycle RV32I/RV64I register and word ops, plus an
// iterative shift-add multiplier (MUL/MULH/MULHSU/MULHU/MULW) behind a small FSM.
module alu_pipe #(
    parameter int XLEN     = 64,
    parameter int MUL_STEP = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         a,
    input  logic [XLEN-1:0]         b,
    input  logic [$clog2(XLEN)-1:0] shamt,
    input  logic [2:0]              func3,
    input  logic [6:0]              func7,
    input  logic                    op_w,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         result,
    output logic                    cmp,
    output logic                    illegal,
    output logic                    busy
);
    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_pend;
    logic                r_out_valid;
    logic [XLEN-1:0]     r_result;
    logic                r_cmp, r_illegal;
    logic [2*XLEN-1:0]   r_acc, r_mcand;
    logic [XLEN-1:0]     r_mplier;
    logic [CW-1:0]       r_cnt;
    logic                r_neg, r_mw;
    logic [1:0]          r_mop;

    logic                w_opw, w_alt, w_shift, w_sh_hi;
    logic                w_legal, w_is_mul;
    logic                w_accept, w_start_mul, w_ld_single, w_ld_mul;
    logic                w_out_free, w_take, w_last;
    logic [31:0]         w_a32, w_b32;
    logic [XLEN-1:0]     w_alu_res;
    logic                w_alu_cmp;
    logic                w_a_neg, w_b_neg;
    logic [XLEN-1:0]     w_a_mag, w_b_mag;
    logic [2*XLEN-1:0]   w_acc_nxt, w_prod_src, w_prod;
    logic [XLEN-1:0]     w_mul_res;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    assign w_opw   = (XLEN == 64) && op_w;
    assign w_alt   = func7[5];
    assign w_shift = (func3 == 3'b001) || (func3 == 3'b101);
    assign w_sh_hi = (SHW > 5) ? shamt[SHW-1] : 1'b0;
    assign w_a32   = a[31:0];
    assign w_b32   = b[31:0];

    // Legality decode; word shifts only see 5 shamt bits, so a set bit 5 is rejected
    always_comb begin
        w_legal  = 1'b0;
        w_is_mul = 1'b0;
        case (func7)
            7'b0000000: w_legal = !w_opw || (func3 == 3'b000) || w_shift;
            7'b0100000: w_legal = (func3 == 3'b000) || (func3 == 3'b101);
            7'b0000001: begin
                w_is_mul = !func3[2];
                w_legal  = !func3[2] && (!w_opw || (func3 == 3'b000));
            end
            default: ;
        endcase
        if (w_opw && w_shift && w_sh_hi && (func7 != 7'b0000001))
            w_legal = 1'b0;
    end

    always_comb begin
        w_alu_res = '0;
        w_alu_cmp = 1'b0;
        case (func3)
            3'b000: w_alu_res = w_opw ? sext32(w_alt ? w_a32 - w_b32 : w_a32 + w_b32)
                                      : (w_alt ? a - b : a + b);
            3'b001: w_alu_res = w_opw ? sext32(w_a32 << shamt[4:0]) : a << shamt;
            3'b010: begin
                w_alu_cmp = $signed(a) < $signed(b);
                w_alu_res = {{(XLEN-1){1'b0}}, w_alu_cmp};
            end
            3'b011: begin
                w_alu_cmp = a < b;
                w_alu_res = {{(XLEN-1){1'b0}}, w_alu_cmp};
            end
            3'b100: w_alu_res = a ^ b;
            3'b101: begin
                if (w_opw)
                    w_alu_res = w_alt ? sext32(32'($signed(w_a32) >>> shamt[4:0]))
                                      : sext32(w_a32 >> shamt[4:0]);
                else
                    w_alu_res = w_alt ? XLEN'($signed(a) >>> shamt) : a >> shamt;
            end
            3'b110: w_alu_res = a | b;
            default: w_alu_res = a & b;
        endcase
        if (!w_legal) begin
            w_alu_res = '0;
            w_alu_cmp = 1'b0;
        end
    end

    assign w_out_free  = !r_out_valid || out_ready;
    assign w_take      = r_out_valid && out_ready;
    assign in_ready    = (r_state == S_IDLE) && w_out_free;
    assign w_accept    = in_valid && in_ready;
    assign w_start_mul = w_accept && w_is_mul && w_legal;
    assign w_ld_single = w_accept && !(w_is_mul && w_legal);
    assign w_last      = (r_state == S_MUL) && (r_cnt == CW'(1));
    assign w_ld_mul    = w_out_free && (w_last || ((r_state == S_DONE) && r_pend));

    // MULH: both signed; MULHSU: a only; MUL/MULHU/MULW take raw bits (low half is sign-agnostic)
    assign w_a_neg = ((func3 == 3'b001) || (func3 == 3'b010)) && a[XLEN-1];
    assign w_b_neg = (func3 == 3'b001) && b[XLEN-1];
    assign w_a_mag = w_opw ? XLEN'(w_a32) : (w_a_neg ? -a : a);
    assign w_b_mag = w_opw ? XLEN'(w_b32) : (w_b_neg ? -b : b);

    always_comb begin
        w_acc_nxt = r_acc;
        for (int j = 0; j < MUL_STEP; j++)
            if (r_mplier[j])
                w_acc_nxt = w_acc_nxt + (r_mcand << j);
    end

    assign w_prod_src = (r_state == S_MUL) ? w_acc_nxt : r_acc;
    assign w_prod     = r_neg ? -w_prod_src : w_prod_src;
    assign w_mul_res  = r_mw ? sext32(w_prod[31:0])
                      : ((r_mop == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_start_mul) w_state_nxt = S_MUL;
            S_MUL:  if (w_last) w_state_nxt = S_DONE;
            S_DONE: if (!r_pend || w_out_free) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_last)
                r_pend <= !w_out_free;
            else if (r_state == S_DONE)
                r_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_cmp       <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_ld_single) begin
            r_out_valid <= 1'b1;
            r_result    <= w_alu_res;
            r_cmp       <= w_alu_cmp;
            r_illegal   <= !w_legal;
        end else if (w_ld_mul) begin
            r_out_valid <= 1'b1;
            r_result    <= w_mul_res;
            r_cmp       <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_take) begin
            r_out_valid <= 1'b0;
        end
    end

    // Multiplicand shifts left while the multiplier drains from the bottom
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_mw     <= 1'b0;
            r_mop    <= 2'b00;
        end else if (w_start_mul) begin
            r_acc    <= '0;
            r_mcand  <= (2*XLEN)'(w_a_mag);
            r_mplier <= w_b_mag;
            r_cnt    <= w_opw ? CW'(32 / MUL_STEP) : CW'(XLEN / MUL_STEP);
            r_neg    <= w_a_neg ^ w_b_neg;
            r_mw     <= w_opw;
            r_mop    <= func3[1:0];
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << MUL_STEP;
            r_mplier <= r_mplier >> MUL_STEP;
            r_cnt    <= r_cnt - CW'(1);
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign cmp       = r_cmp;
    assign illegal   = r_illegal;
    assign busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe (XLEN=64, MUL_STEP=1) with hand-computed expectations.
module tb_alu_pipe;
    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [63:0] a, b;
    logic [5:0]  shamt;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        op_w;
    logic        out_valid, out_ready;
    logic [63:0] result;
    logic        cmp, illegal, busy;

    int checks = 0;
    int failures = 0;

    alu_pipe #(.XLEN(64), .MUL_STEP(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .shamt(shamt), .func3(func3), .func7(func7), .op_w(op_w),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cmp(cmp), .illegal(illegal), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [6:0] f7, input logic w,
                         input logic [63:0] aa, input logic [63:0] bb, input logic [5:0] sh);
        func3 = f3; func7 = f7; op_w = w; a = aa; b = bb; shamt = sh;
        in_valid = 1'b1;
    endtask

    // Counts cycles from the accept edge until out_valid, flagging any in_ready=1 meanwhile
    task automatic wait_out(output int n, output int rdy_bad);
        n = 1;
        rdy_bad = 0;
        while (!out_valid && n < 200) begin
            if (in_ready) rdy_bad++;
            tick();
            n++;
        end
    endtask

    initial begin
        int n, bad;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; shamt = '0; func3 = '0; func7 = '0; op_w = 1'b0;
        tick(); tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_flags", {61'd0, cmp, illegal, busy}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Back-to-back single-cycle ops
        issue(3'b000, 7'b0000000, 1'b0, 64'd5, 64'd7, 6'd0);
        tick();
        chk("add_res", result, 64'd12);
        chk("add_vld", 64'(out_valid), 64'd1);
        issue(3'b000, 7'b0100000, 1'b0, 64'd3, 64'd5, 6'd0);
        tick();
        chk("sub_res", result, 64'hFFFF_FFFF_FFFF_FFFE);
        issue(3'b010, 7'b0000000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd0);
        tick();
        chk("slt_res", result, 64'd1);
        chk("slt_cmp", 64'(cmp), 64'd1);
        issue(3'b011, 7'b0000000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd0);
        tick();
        chk("sltu_res", result, 64'd0);
        chk("sltu_cmp", 64'(cmp), 64'd0);
        chk("sltu_vld", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        tick();
        chk("drain_vld", 64'(out_valid), 64'd0);

        // Word ops
        issue(3'b101, 7'b0100000, 1'b1, 64'h0000_0000_8000_0000, 64'd0, 6'd4);
        tick();
        chk("sraw_res", result, 64'hFFFF_FFFF_F800_0000);
        chk("sraw_ill", 64'(illegal), 64'd0);
        issue(3'b000, 7'b0000000, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd1, 6'd0);
        tick();
        chk("addw_res", result, 64'hFFFF_FFFF_8000_0000);
        issue(3'b001, 7'b0000000, 1'b1, 64'h1234, 64'd0, 6'd32);
        tick();
        chk("sllw32_ill", 64'(illegal), 64'd1);
        chk("sllw32_res", result, 64'd0);

        // Edge operands
        issue(3'b101, 7'b0100000, 1'b0, 64'h8000_0000_0000_0000, 64'd0, 6'd63);
        tick();
        chk("sra63_res", result, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(3'b000, 7'b0100000, 1'b0, 64'h8000_0000_0000_0000, 64'd1, 6'd0);
        tick();
        chk("sub_ovf", result, 64'h7FFF_FFFF_FFFF_FFFF);
        issue(3'b001, 7'b0000000, 1'b0, 64'h1, 64'd0, 6'd63);
        tick();
        chk("sll63_res", result, 64'h8000_0000_0000_0000);

        // Illegal ops
        issue(3'b100, 7'b0000001, 1'b0, 64'd9, 64'd3, 6'd0);
        tick();
        chk("div_ill", 64'(illegal), 64'd1);
        chk("div_res", result, 64'd0);
        chk("div_busy", 64'(busy), 64'd0);
        issue(3'b111, 7'b0100000, 1'b0, 64'hFF, 64'hFF, 6'd0);
        tick();
        chk("alt_and_ill", 64'(illegal), 64'd1);
        issue(3'b001, 7'b0000001, 1'b1, 64'd2, 64'd3, 6'd0);
        tick();
        chk("mulhw_ill", 64'(illegal), 64'd1);
        chk("mulhw_busy", 64'(busy), 64'd0);
        in_valid = 1'b0;
        tick();

        // Backpressure
        out_ready = 1'b0;
        issue(3'b100, 7'b0000000, 1'b0, 64'hF0F0, 64'h0FF0, 6'd0);
        tick();
        in_valid = 1'b0;
        chk("xor_res", result, 64'hFF00);
        chk("bp_rdy1", 64'(in_ready), 64'd0);
        tick();
        chk("bp_hold2", result, 64'hFF00);
        tick();
        chk("bp_hold3", {result[62:0], out_valid}, {63'h0_FF00 << 0, 1'b1});
        chk("bp_rdy3", 64'(in_ready), 64'd0);
        issue(3'b110, 7'b0000000, 1'b0, 64'd1, 64'd2, 6'd0);
        #1;
        chk("bp_rdy_blk", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_open", 64'(in_ready), 64'd1);
        tick();
        chk("bp_or_res", result, 64'd3);
        chk("bp_or_vld", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        tick();
        chk("bp_drain", 64'(out_valid), 64'd0);

        // MULH most-negative squared
        issue(3'b001, 7'b0000001, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 6'd0);
        tick();
        in_valid = 1'b0; a = 64'h1234_5678; b = 64'h9;
        chk("mulh_busy", 64'(busy), 64'd1);
        wait_out(n, bad);
        chk("mulh_lat", 64'(n), 64'd65);
        chk("mulh_inrdy", 64'(bad), 64'd0);
        chk("mulh_res", result, 64'h4000_0000_0000_0000);
        tick();
        chk("mulh_idle", {62'd0, busy, in_ready}, 64'd1);

        // MULHSU a=-1 b=2
        issue(3'b010, 7'b0000001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd0);
        tick();
        in_valid = 1'b0;
        wait_out(n, bad);
        chk("mulhsu_res", result, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();

        // MUL low half with a negative operand
        issue(3'b000, 7'b0000001, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 6'd0);
        tick();
        in_valid = 1'b0;
        wait_out(n, bad);
        chk("mul_res", result, 64'hFFFF_FFFF_FFFF_FFF1);
        tick();

        // MULW: 3 * 0x8000_0001 -> low word 0x8000_0003, sign-extended
        issue(3'b000, 7'b0000001, 1'b1, 64'h1_0000_0003, 64'h8000_0001, 6'd0);
        tick();
        in_valid = 1'b0;
        wait_out(n, bad);
        chk("mulw_lat", 64'(n), 64'd33);
        chk("mulw_res", result, 64'hFFFF_FFFF_8000_0003);
        tick();

        // Reset mid-multiply
        issue(3'b000, 7'b0000001, 1'b0, 64'd3, 64'd5, 6'd0);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        chk("mid_busy_pre", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        tick();
        rst_n = 1'b1;
        issue(3'b000, 7'b0000000, 1'b0, 64'd1, 64'd1, 6'd0);
        #1;
        chk("mid_rdy", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("mid_add", result, 64'd2);
        tick();
        chk("mid_no_stale", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
